// File: rtl/ldpc_syndrome_iter.sv
// ldpc_syndrome_iter: streaming LDPC syndrome check with per-iteration report and early-stop decision.
// Ports:
//   clk, xrst       clock (rising edge) and asynchronous active-low reset
//   i_start         pulse: abort any frame and begin a new one at iteration 1
//   i_data/i_val    one check row per beat, ROW_WEIGHT signed LLR lanes
//   i_rdy           high while accumulating rows
//   o_val/o_rdy     iteration report handshake
//   o_pass          every check of the iteration satisfied
//   o_fail_cnt      number of unsatisfied checks
//   o_iter          1-based iteration number of the report
//   o_stop          o_pass or last allowed iteration
module ldpc_syndrome_iter #(
    parameter int CHECK_NUM  = 4,
    parameter int ROW_WEIGHT = 4,
    parameter int WIDTH      = 8,
    parameter int MAX_ITER   = 10
) (
    input  logic                              clk,
    input  logic                              xrst,
    input  logic                              i_start,
    input  logic [ROW_WEIGHT*WIDTH-1:0]       i_data,
    input  logic                              i_val,
    output logic                              i_rdy,
    output logic                              o_val,
    input  logic                              o_rdy,
    output logic                              o_pass,
    output logic [$clog2(CHECK_NUM+1)-1:0]    o_fail_cnt,
    output logic [$clog2(MAX_ITER+1)-1:0]     o_iter,
    output logic                              o_stop
);
    localparam int FW = $clog2(CHECK_NUM + 1);
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int RW = $clog2(CHECK_NUM);
    localparam logic [RW-1:0] LAST_ROW = RW'(CHECK_NUM - 1);
    localparam logic [IW-1:0] LAST_ITER = IW'(MAX_ITER);
    localparam logic [IW-1:0] ONE_ITER = IW'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t          r_state;
    logic [RW-1:0]   r_row;
    logic [FW-1:0]   r_fail;
    logic [IW-1:0]   r_iter;
    logic            w_par;
    logic [FW-1:0]   w_sum;
    logic            w_pass;

    // A lane decides 1 when its LLR is negative or exactly zero.
    always_comb begin
        w_par = 1'b0;
        for (int k = 0; k < ROW_WEIGHT; k++)
            w_par = w_par ^ (i_data[k*WIDTH+WIDTH-1] | ~|i_data[k*WIDTH +: WIDTH]);
    end

    assign w_sum  = r_fail + {{(FW-1){1'b0}}, w_par};
    assign w_pass = (w_sum == '0);
    assign i_rdy  = (r_state == ACCUM);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state    <= IDLE;
            r_row      <= '0;
            r_fail     <= '0;
            r_iter     <= '0;
            o_val      <= 1'b0;
            o_pass     <= 1'b0;
            o_fail_cnt <= '0;
            o_iter     <= '0;
            o_stop     <= 1'b0;
        end else if (i_start) begin
            r_state    <= ACCUM;
            r_row      <= '0;
            r_fail     <= '0;
            r_iter     <= ONE_ITER;
            o_val      <= 1'b0;
            o_pass     <= 1'b0;
            o_fail_cnt <= '0;
            o_iter     <= '0;
            o_stop     <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: if (i_val) begin
                    r_row  <= (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
                    r_fail <= w_sum;
                    if (r_row == LAST_ROW) begin
                        r_state    <= REPORT;
                        o_val      <= 1'b1;
                        o_pass     <= w_pass;
                        o_fail_cnt <= w_sum;
                        o_iter     <= r_iter;
                        o_stop     <= w_pass | (r_iter == LAST_ITER);
                    end
                end
                REPORT: if (o_rdy) begin
                    r_state    <= o_stop ? IDLE : ACCUM;
                    r_iter     <= o_stop ? r_iter : r_iter + ONE_ITER;
                    r_row      <= '0;
                    r_fail     <= '0;
                    o_val      <= 1'b0;
                    o_pass     <= 1'b0;
                    o_fail_cnt <= '0;
                    o_iter     <= '0;
                    o_stop     <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
